// File: rtl/flag_cond_unit.sv
// Architectural FLAGS register with a PUSHF/POPF save stack and a branch-condition
// evaluator behind a one-deep valid/ready output register.
//
// state | meaning
// IDLE  | no result held, res_valid=0
// HOLD  | result held in res_taken until res_ready
module flag_cond_unit #(
   parameter int STK_DEPTH = 4,
   parameter int STK_AW    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flags_we,
   input  logic       sf_in,
   input  logic       cf_in,
   input  logic       of_in,
   input  logic       pf_in,
   input  logic       zf_in,
   input  logic       push,
   input  logic       pop,
   input  logic       eval_valid,
   input  logic [3:0] eval_cond,
   output logic       eval_ready,
   output logic       res_valid,
   input  logic       res_ready,
   output logic       res_taken,
   output logic [4:0] flags_out,
   output logic       stk_empty,
   output logic       stk_full,
   output logic       stk_err
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t            state;
   logic [STK_AW-1:0] sp;
   logic              occ_full;
   logic [4:0]        stk [STK_DEPTH];

   logic [4:0]        flags_in_v;
   logic [STK_AW-1:0] sp_m1;
   logic [4:0]        stk_top;
   logic              push_ok;
   logic              pop_ok;
   logic              stk_bad;
   logic [4:0]        eff;
   logic              accept;

   function automatic logic cond_true(input logic [4:0] f, input logic [3:0] c);
      logic s, cy, o, p, z, base;
      {s, cy, o, p, z} = f;
      base = 1'b0;
      case (c[3:1])
         3'd0: base = o;
         3'd1: base = cy;
         3'd2: base = z;
         3'd3: base = cy | z;
         3'd4: base = s;
         3'd5: base = p;
         3'd6: base = s ^ o;
         3'd7: base = z | (s ^ o);
         default: base = 1'b0;
      endcase
      return base ^ c[0];
   endfunction

   // sp alone cannot tell empty from full once it wraps; occ_full disambiguates
   assign stk_full   = occ_full && (sp == '0);
   assign stk_empty  = !occ_full && (sp == '0);

   assign flags_in_v = {sf_in, cf_in, of_in, pf_in, zf_in};
   assign sp_m1      = sp - STK_AW'(1);
   assign stk_top    = stk[sp_m1];
   assign push_ok    = push && !pop && !stk_full;
   assign pop_ok     = pop && !push && !stk_empty;
   assign stk_bad    = (push && pop) || (push && stk_full) || (pop && stk_empty);
   assign eff        = pop_ok ? stk_top : (flags_we ? flags_in_v : flags_out);
   assign eval_ready = !res_valid || res_ready;
   assign accept     = eval_valid && eval_ready;

   always_ff @(posedge clk) begin
      if (!rst && push_ok)
         stk[sp] <= flags_out;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flags_out <= '0;
         sp        <= '0;
         occ_full  <= 1'b0;
         stk_err   <= 1'b0;
         state     <= IDLE;
         res_valid <= 1'b0;
         res_taken <= 1'b0;
      end else begin
         if (push_ok) begin
            sp <= sp + STK_AW'(1);
            if (sp == STK_AW'(STK_DEPTH - 1))
               occ_full <= 1'b1;
         end else if (pop_ok) begin
            sp       <= sp_m1;
            occ_full <= 1'b0;
         end
         if (stk_bad)
            stk_err <= 1'b1;

         if (pop_ok)
            flags_out <= stk_top;
         else if (flags_we)
            flags_out <= flags_in_v;

         case (state)
            IDLE: begin
               if (accept) begin
                  state     <= HOLD;
                  res_valid <= 1'b1;
                  res_taken <= cond_true(eff, eval_cond);
               end
            end
            HOLD: begin
               if (accept) begin
                  res_taken <= cond_true(eff, eval_cond);
               end else if (res_ready) begin
                  state     <= IDLE;
                  res_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               res_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_flag_cond_unit.sv
// Randomized and directed bench for flag_cond_unit: a cycle model predicts FLAGS/stack state
// and queues expected branch results that a separate monitor retires on each handshake.
module tb_flag_cond_unit;
   localparam int STK_DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst, flags_we, sf_in, cf_in, of_in, pf_in, zf_in, push, pop;
   logic       eval_valid, eval_ready, res_valid, res_ready, res_taken;
   logic [3:0] eval_cond;
   logic [4:0] flags_out;
   logic       stk_empty, stk_full, stk_err;

   always #5 clk = ~clk;

   flag_cond_unit #(.STK_DEPTH(STK_DEPTH), .STK_AW(2)) dut (
      .clk(clk), .rst(rst), .flags_we(flags_we),
      .sf_in(sf_in), .cf_in(cf_in), .of_in(of_in), .pf_in(pf_in), .zf_in(zf_in),
      .push(push), .pop(pop), .eval_valid(eval_valid), .eval_cond(eval_cond),
      .eval_ready(eval_ready), .res_valid(res_valid), .res_ready(res_ready),
      .res_taken(res_taken), .flags_out(flags_out), .stk_empty(stk_empty),
      .stk_full(stk_full), .stk_err(stk_err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [4:0] m_flags;
   logic [4:0] m_stk[$];
   bit         m_err, m_rv, m_rt;
   bit         m_known = 1'b0;
   bit         exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Jcc truth table written directly from the condition names
   function automatic bit model_cond(input logic [4:0] f, input logic [3:0] code);
      bit s = f[4], c = f[3], o = f[2], p = f[1], z = f[0];
      bit l = (s != o);
      case (code)
         4'h0: return o;        4'h1: return !o;
         4'h2: return c;        4'h3: return !c;
         4'h4: return z;        4'h5: return !z;
         4'h6: return c || z;   4'h7: return !(c || z);
         4'h8: return s;        4'h9: return !s;
         4'hA: return p;        4'hB: return !p;
         4'hC: return l;        4'hD: return !l;
         4'hE: return z || l;   default: return !(z || l);
      endcase
   endfunction

   task automatic step(input bit r, input bit fwe, input logic [4:0] fin, input bit pu,
                       input bit po, input bit ev, input logic [3:0] c, input bit rr);
      logic [4:0] eff;
      bit push_ok, pop_ok, rdy, acc, bad;
      rst = r; flags_we = fwe; {sf_in, cf_in, of_in, pf_in, zf_in} = fin;
      push = pu; pop = po; eval_valid = ev; eval_cond = c; res_ready = rr;
      @(negedge clk);
      push_ok = pu && !po && (m_stk.size() < STK_DEPTH);
      pop_ok  = po && !pu && (m_stk.size() > 0);
      eff     = pop_ok ? m_stk[$] : (fwe ? fin : m_flags);
      rdy     = !m_rv || rr;
      acc     = ev && rdy;
      if (m_known) begin
         chk("flags_out", 32'(flags_out), 32'(m_flags));
         chk("stk_empty", 32'(stk_empty), 32'(m_stk.size() == 0));
         chk("stk_full", 32'(stk_full), 32'(m_stk.size() == STK_DEPTH));
         chk("stk_err", 32'(stk_err), 32'(m_err));
         chk("res_valid", 32'(res_valid), 32'(m_rv));
         chk("eval_ready", 32'(eval_ready), 32'(rdy));
         if (m_rv) chk("res_taken_held", 32'(res_taken), 32'(m_rt));
      end
      if (acc && !r) exp_q.push_back(model_cond(eff, c));
      @(posedge clk);
      if (r) begin
         m_flags = '0; m_stk.delete(); m_err = 0; m_rv = 0; m_rt = 0;
         exp_q.delete(); m_known = 1'b1;
      end else begin
         bad = (pu && po) || (pu && !po && !push_ok) || (po && !pu && !pop_ok);
         if (bad) m_err = 1'b1;
         if (pop_ok) m_flags = m_stk.pop_back();
         else begin
            if (push_ok) m_stk.push_back(m_flags);
            if (fwe) m_flags = fin;
         end
         if (acc) begin
            m_rv = 1'b1;
            m_rt = model_cond(eff, c);
         end else if (rr) m_rv = 1'b0;
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 5'd0, 0, 0, 0, 4'd0, 1);
   endtask

   // Scoreboard monitor: retires one expected result per completed output handshake
   initial begin
      bit e;
      forever begin
         @(negedge clk);
         if (res_valid === 1'b1 && res_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_unexpected: got result %0b with nothing expected at %0t", res_taken, $time);
            end else begin
               e = exp_q.pop_front();
               chk("sb_res_taken", 32'(res_taken), 32'(e));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] vals [4];
      vals = '{5'h11, 5'h0A, 5'h15, 5'h07};
      rst = 1; flags_we = 0; {sf_in, cf_in, of_in, pf_in, zf_in} = '0;
      push = 0; pop = 0; eval_valid = 0; eval_cond = '0; res_ready = 1;
      @(posedge clk); #1;
      step(1, 0, 5'd0, 0, 0, 0, 4'd0, 1);
      step(1, 0, 5'd0, 0, 0, 0, 4'd0, 1);
      chk("reset_flags", 32'(flags_out), 32'd0);
      chk("reset_empty", 32'(stk_empty), 32'd1);
      chk("reset_valid", 32'(res_valid), 32'd0);

      // T1
      step(0, 1, 5'b01001, 0, 0, 0, 4'd0, 1);
      chk("t1_flags", 32'(flags_out), 32'b01001);
      step(0, 0, 5'd0, 0, 0, 1, 4'h6, 1);
      chk("t1_cond6", 32'(res_taken), 32'd1);
      step(0, 0, 5'd0, 0, 0, 1, 4'h7, 1);
      chk("t1_cond7", 32'(res_taken), 32'd0);
      idle(2);

      // T2: forwarded flags_we into a same-cycle evaluation
      step(0, 1, 5'b00000, 0, 0, 0, 4'd0, 1);
      step(0, 1, 5'b10000, 0, 0, 1, 4'hC, 1);
      chk("t2_fwd_C", 32'(res_taken), 32'd1);
      step(0, 0, 5'd0, 0, 0, 1, 4'hD, 1);
      chk("t2_D", 32'(res_taken), 32'd0);
      idle(2);

      // T3: every code, back to back
      step(0, 1, 5'b10100, 0, 0, 0, 4'd0, 1);
      for (int k = 0; k < 16; k++) step(0, 0, 5'd0, 0, 0, 1, 4'(k), 1);
      idle(2);

      // T4: fill, overflow, drain in LIFO order, underflow
      for (int i = 0; i < 4; i++) begin
         step(0, 1, vals[i], 0, 0, 0, 4'd0, 1);
         step(0, 0, 5'd0, 1, 0, 0, 4'd0, 1);
      end
      chk("t4_full", 32'(stk_full), 32'd1);
      step(0, 1, 5'h1F, 1, 0, 0, 4'd0, 1);
      chk("t4_overflow_err", 32'(stk_err), 32'd1);
      for (int i = 3; i >= 0; i--) begin
         step(0, 0, 5'd0, 0, 1, 0, 4'd0, 1);
         chk("t4_pop_lifo", 32'(flags_out), 32'(vals[i]));
      end
      chk("t4_empty", 32'(stk_empty), 32'd1);
      step(0, 0, 5'd0, 0, 1, 0, 4'd0, 1);
      chk("t4_underflow_flags", 32'(flags_out), 32'(vals[0]));
      idle(1);

      // T5: held result survives FLAGS changes, then back-to-back
      step(1, 0, 5'd0, 0, 0, 0, 4'd0, 1);
      step(0, 1, 5'b00001, 0, 0, 0, 4'd0, 1);
      step(0, 0, 5'd0, 0, 0, 1, 4'h4, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 5'b00000, 0, 0, 1, 4'h4, 0);
         chk("t5_hold_valid", 32'(res_valid), 32'd1);
         chk("t5_hold_taken", 32'(res_taken), 32'd1);
         chk("t5_ready_low", 32'(eval_ready), 32'd0);
      end
      step(0, 0, 5'd0, 0, 0, 1, 4'h4, 1);
      chk("t5_b2b_taken", 32'(res_taken), 32'd0);
      idle(2);

      // T6: pop beats flags_we; reset aborts a held result
      step(0, 1, 5'b00001, 0, 0, 0, 4'd0, 1);
      step(0, 0, 5'd0, 1, 0, 0, 4'd0, 1);
      step(0, 1, 5'b11110, 0, 0, 0, 4'd0, 1);
      step(0, 1, 5'b10101, 0, 1, 0, 4'd0, 1);
      chk("t6_pop_wins", 32'(flags_out), 32'b00001);
      step(0, 0, 5'd0, 0, 0, 1, 4'h4, 0);
      step(1, 0, 5'd0, 0, 0, 0, 4'd0, 0);
      chk("t6_rst_valid", 32'(res_valid), 32'd0);
      idle(2);

      // Random phase
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, 5'($urandom),
              $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 1) == 1, 4'($urandom), $urandom_range(0, 3) != 0);
      end
      idle(4);
      chk("sb_drain", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
